// File: rtl/codec_pkg.sv
// Shared types and widths for the XOR codec and the arbiter that feeds it.
package codec_pkg;

  localparam int DATA_W = 64;

  typedef enum logic {
    REQ_TX = 1'b0,
    REQ_RX = 1'b1
  } req_id_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  function automatic logic [1:0] req_onehot(input req_id_t id);
    return (id == REQ_RX) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/codec.sv
// Stateless XOR codec: output is the operand masked with the key.
module codec #(
  parameter int DATA_W = codec_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] key,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = data_i ^ key;

endmodule

// File: rtl/codec_arbiter.sv
// Round-robin share of one XOR codec between the TX (req 0) and RX (req 1)
// paths, with the key register and a one-entry result buffer.
//
// state     | meaning
// BUF_EMPTY | no result held, rsp_valid = 0
// BUF_FULL  | result held for buf_owner until that requester drains it
module codec_arbiter
  import codec_pkg::*;
#(
  parameter int DATA_W = codec_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr_en,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic              key_valid,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  logic [DATA_W-1:0] key_q;
  logic              key_valid_q;
  logic [DATA_W-1:0] buf_data;
  req_id_t           buf_owner;
  req_id_t           last_q;
  req_id_t           grant_id;
  logic              grant_valid;
  logic              drain;
  logic              avail;
  logic              fire;
  logic [DATA_W-1:0] codec_in;
  logic [DATA_W-1:0] codec_out;
  buf_state_t        state;
  buf_state_t        state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else if (key_wr_en) begin
      key_q       <= key_wr_data;
      key_valid_q <= 1'b1;
    end
  end

  assign key_valid = key_valid_q;

  // Contested cycles go to whoever was not served last.
  always_comb begin
    grant_valid = |req_valid;
    grant_id    = REQ_TX;
    case (req_valid)
      2'b01:   grant_id = REQ_TX;
      2'b10:   grant_id = REQ_RX;
      2'b11:   grant_id = (last_q == REQ_TX) ? REQ_RX : REQ_TX;
      default: grant_id = REQ_TX;
    endcase
  end

  assign busy      = (state == BUF_FULL);
  assign drain     = busy & rsp_ready[buf_owner];
  assign avail     = ~busy | drain;
  assign req_ready = (key_valid_q && grant_valid && avail) ? req_onehot(grant_id) : 2'b00;
  assign fire      = |(req_ready & req_valid);
  assign rsp_valid = busy ? req_onehot(buf_owner) : 2'b00;
  assign rsp_data  = buf_data;

  assign codec_in = (grant_id == REQ_RX) ? req_data1 : req_data0;

  codec #(
    .DATA_W (DATA_W)
  ) u_codec (
    .data_i (codec_in),
    .key    (key_q),
    .data_o (codec_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BUF_EMPTY: if (fire)           state_next = BUF_FULL;
      BUF_FULL:  if (drain && !fire) state_next = BUF_EMPTY;
      default:                       state_next = BUF_EMPTY;
    endcase
  end

  // The codec sees the pre-edge key, so a same-cycle key write does not leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data  <= '0;
      buf_owner <= REQ_TX;
      last_q    <= REQ_RX;
    end else if (fire) begin
      buf_data  <= codec_out;
      buf_owner <= grant_id;
      last_q    <= grant_id;
    end
  end

endmodule

// File: doc/codec_arbiter.md
# codec_arbiter

Shares the single XOR `codec` datapath between two requesters with round-robin arbitration. The requesters are the ICB-to-APB write path (req 0, TX) and the APB-to-ICB read-return path (req 1, RX). The block holds the 64-bit key register and a one-entry registered result buffer. Each result is returned only to the requester that issued it, under valid/ready handshakes. It sits between the bridge's ICB-side and APB-side datapaths.

## Interface
Parameters:
- `DATA_W`, 64, data and key width; must equal the codec width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_wr_en`  in  1  load key this cycle.
- `key_wr_data`  in  DATA_W  new key value.
- `key_valid`  out  1  key loaded since reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept.
- `req_data0`, `req_data1`  in  DATA_W  operands.
- `rsp_valid`  out  2  result valid, one-hot to owner.
- `rsp_ready`  in  2  per-requester result accept.
- `rsp_data`  out  DATA_W  result, shared bus; meaningful only for the asserted `rsp_valid` bit.
- `busy`  out  1  result buffer occupied.

## Operation
- **Key register**
  - On `key_wr_en`, key ← `key_wr_data` and `key_valid` ← 1.
  - `key_valid` clears only on reset.
  - No request is granted while `key_valid` = 0.
- **Buffer**
  - One entry: {data, owner}.
  - Full when `busy` = 1.
  - Drain ("drain") = `rsp_valid[owner]` & `rsp_ready[owner]`.
  - Buffer available = !busy | drain.
- **Arbitration**
  - `last` pointer holds the last requester served. Reset value is 1, so req 0 wins the first contest.
  - Only req i valid: grant i.
  - Both valid: grant !last.
  - Neither valid: no grant.
- **Ready**
  - `req_ready[i]` = key_valid & grant==i & buffer available.
  - At most one bit is set.
  - Combinational from `req_valid`, `rsp_ready` and state.
- **Fire on req i**
  - buffer ← {req_data_i ^ key, i}.
  - `last` ← i.
  - `busy` ← 1.
- **States**
  - EMPTY → FULL on fire.
  - FULL → EMPTY on drain without fire.
  - FULL → FULL on drain with fire: back-to-back operation, one result per cycle.
- **Key and data**
  - XOR uses the key register value present at the fire edge.
  - A key write in the same cycle as a fire does not affect that operation; the old key is used.
  - A key write while the buffer is FULL does not alter the held result.
- **Dropped requests**
  - `req_valid` deasserted before fire has no effect. Requesters must hold valid until ready; the block does not check this.
  - A stale `rsp_ready` from the non-owner is ignored.

## Timing
- **Reset values (async assert, sync deassert at the source)**
  - key = 0, `key_valid` = 0.
  - `busy` = 0, `rsp_valid` = 2'b00, `rsp_data` = 0.
  - `last` = 1, `req_ready` = 2'b00.
- **Latency:** fire at edge N → `rsp_valid[i]` = 1 and `rsp_data` valid after edge N, i.e. visible in cycle N+1.
- **Result hold:** the result is held stable until drain.
- **Throughput:** 1 op/cycle with `rsp_ready` held high. Alternating TX/RX under continuous dual requests.
- **Backpressure:** if the owner holds `rsp_ready` low, both `req_ready` stay 0.
- **Key write:** `key_valid` rises the cycle after `key_wr_en`. The first grant is possible in that cycle.
- **Reset mid-operation:** the held result is discarded and the key is lost. Requesters must reissue after the key is reloaded.

## Structure
- **Shared `codec_pkg`:**
  - `DATA_W` = 64.
  - `typedef enum logic {REQ_TX = 1'b0, REQ_RX = 1'b1} req_id_t`, used for `last` and the buffer owner field.
- **Sub-module:** one instance of the existing `codec`.
  - `data_i` = muxed granted operand.
  - `key` = key register.
  - `data_o` feeds the buffer.
- **Target size:** about 150 lines of RTL.

## Test plan
- **Key gating:** with no key write, hold `req_valid` = 2'b01 for 5 cycles → `req_ready` stays 0. Then write key 64'hFFFF_0000_FFFF_0000 → the next cycle fires. `rsp_data` = 64'h1234_5678_9ABC_DEF0 ^ key = 64'hEDCB_5678_6543_DEF0 on `rsp_valid` = 2'b01.
- **Round-robin:** key = 0. Both valid continuously, `rsp_ready` = 2'b11, req_data0 = 64'hA, req_data1 = 64'hB. Expect grants 0,1,0,1 and `rsp_data` A,B,A,B, one per cycle.
- **Backpressure:** fire req 1, hold `rsp_ready[1]` = 0 for 4 cycles while req 0 is valid → `req_ready` = 0 and `rsp_data` stable. Release `rsp_ready[1]` → req 0 fires in the same cycle as the drain.
- **Key race:** `key_wr_en` with 64'h1 in the same cycle as a fire with old key 64'h0 and data 64'h10 → result 64'h10. The next op with data 64'h10 → 64'h11.
- **Mid-operation reset:** drop `rst_n` while `busy` = 1 → outputs immediately return to their reset values and `key_valid` = 0. Requests are stalled until a new key write.
- **Non-owner ready:** `rsp_ready` = 2'b10 while owner = 0 → no drain and `rsp_valid` stays 2'b01.
